// File: rtl/fe_test_pkg.sv
// Shared types and helpers for the front-end test generator: the mode encoding,
// the positive full-scale constant and a saturating negate.
package fe_test_pkg;

   typedef enum logic [2:0] {
      FE_BYPASS  = 3'd0,
      FE_POS_DC  = 3'd1,
      FE_NEG_DC  = 3'd2,
      FE_TRI     = 3'd3,
      FE_IMPULSE = 3'd4,
      FE_SQUARE  = 3'd5,
      FE_SAW     = 3'd6,
      FE_ZERO    = 3'd7
   } fe_mode_e;

   // Helpers work in 64-bit signed arithmetic; callers size-cast to their sample width.
   function automatic logic signed [63:0] fe_maxp(input int unsigned data_w);
      return (64'sd1 <<< (data_w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] fe_sat_neg(input logic signed [63:0] x,
                                                     input int unsigned data_w);
      logic signed [63:0] neg;
      neg = -x;
      return (neg > fe_maxp(data_w)) ? fe_maxp(data_w) : neg;
   endfunction

endpackage

// File: rtl/fe_smp_tick.sv
// Sample-rate divider: emits a one-cycle registered tick every smp_div+1 clocks.
module fe_smp_tick #(
   parameter int DIV_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [DIV_W-1:0] smp_div,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt;

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt >= smp_div) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/fe_test_gen.sv
// Multi-channel test audio source: waveform state, per-channel enable/invert and the
// registered output mux that replaces the PCM stream when a test mode is selected.
module fe_test_gen
   import fe_test_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 12,
   parameter int PER_W  = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run,
   input  logic [2:0]               mode,
   input  logic [DIV_W-1:0]         smp_div,
   input  logic [DATA_W-1:0]        tri_inc,
   input  logic [PER_W-1:0]         period,
   input  logic [NUM_CH-1:0]        ch_enable,
   input  logic [NUM_CH-1:0]        ch_invert,
   input  logic                     pcm_valid,
   input  logic [NUM_CH*DATA_W-1:0] pcm_data,
   output logic                     out_valid,
   output logic [NUM_CH*DATA_W-1:0] out_data
);

   // Two guard bits keep acc +/- tri_inc exact even for a full-scale unsigned step.
   localparam int                        SUM_W    = DATA_W + 2;
   localparam logic signed [DATA_W-1:0] MAXP     = DATA_W'(fe_maxp(DATA_W));
   localparam logic signed [DATA_W-1:0] MINN     = -MAXP;
   localparam logic signed [SUM_W-1:0]  SUM_MAXP = SUM_W'(MAXP);
   localparam logic signed [SUM_W-1:0]  SUM_MINN = SUM_W'(MINN);

   fe_mode_e                  mode_e;
   logic                      tick;
   logic signed [DATA_W-1:0]  acc, acc_nxt;
   logic                      dir_down, dir_nxt;
   logic        [DATA_W-1:0]  saw;
   logic        [PER_W-1:0]   per_cnt;
   logic                      sq_lvl;
   logic signed [SUM_W-1:0]   tri_sum;
   logic signed [DATA_W-1:0]  sample, ch_src;
   logic [NUM_CH*DATA_W-1:0]  post;

   assign mode_e = fe_mode_e'(mode);

   fe_smp_tick #(.DIV_W(DIV_W)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .smp_div (smp_div),
      .tick    (tick)
   );

   // Triangle reflects at the rails by clamping, so it never emits the most-negative code.
   always_comb begin
      acc_nxt = acc;
      dir_nxt = dir_down;
      tri_sum = '0;
      if (!dir_down) begin
         tri_sum = SUM_W'(acc) + $signed({2'b00, tri_inc});
         if (tri_sum > SUM_MAXP) begin
            acc_nxt = MAXP;
            dir_nxt = 1'b1;
         end else begin
            acc_nxt = DATA_W'(tri_sum);
         end
      end else begin
         tri_sum = SUM_W'(acc) - $signed({2'b00, tri_inc});
         if (tri_sum < SUM_MINN) begin
            acc_nxt = MINN;
            dir_nxt = 1'b0;
         end else begin
            acc_nxt = DATA_W'(tri_sum);
         end
      end
   end

   always_comb begin
      case (mode_e)
         FE_POS_DC:  sample = MAXP;
         FE_NEG_DC:  sample = MINN;
         FE_TRI:     sample = acc;
         FE_IMPULSE: sample = (per_cnt == '0) ? MAXP : '0;
         FE_SQUARE:  sample = sq_lvl ? MAXP : MINN;
         FE_SAW:     sample = $signed(saw);
         default:    sample = '0;
      endcase
   end

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      post   = '0;
      ch_src = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_src = (mode_e == FE_BYPASS) ? $signed(pcm_data[i*DATA_W +: DATA_W]) : sample;
         if (!ch_enable[i])
            post[i*DATA_W +: DATA_W] = '0;
         else if (ch_invert[i])
            post[i*DATA_W +: DATA_W] = DATA_W'(fe_sat_neg(64'(ch_src), DATA_W));
         else
            post[i*DATA_W +: DATA_W] = ch_src;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         acc       <= '0;
         dir_down  <= 1'b0;
         saw       <= '0;
         per_cnt   <= '0;
         sq_lvl    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (mode_e == FE_BYPASS) begin
         out_valid <= pcm_valid;
         if (pcm_valid)
            out_data <= post;
      end else begin
         out_valid <= tick;
         if (tick) begin
            // Emit the pre-advance sample, so the first output after run rises is the initial state.
            out_data <= post;
            acc      <= acc_nxt;
            dir_down <= dir_nxt;
            saw      <= saw + tri_inc;
            if (per_cnt >= period) begin
               per_cnt <= '0;
               sq_lvl  <= ~sq_lvl;
            end else begin
               per_cnt <= per_cnt + PER_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fe_test_gen.sv
// Directed bench for fe_test_gen: one task per scenario, hand-computed expected samples.
module tb_fe_test_gen;

   localparam int DATA_W = 24;
   localparam int NUM_CH = 2;
   localparam int DIV_W  = 12;
   localparam int PER_W  = 10;

   localparam logic [23:0] MAXP = 24'h7FFFFF;
   localparam logic [23:0] MINN = 24'h800001;

   logic                     clk;
   logic                     reset;
   logic                     run;
   logic [2:0]               mode;
   logic [DIV_W-1:0]         smp_div;
   logic [DATA_W-1:0]        tri_inc;
   logic [PER_W-1:0]         period;
   logic [NUM_CH-1:0]        ch_enable;
   logic [NUM_CH-1:0]        ch_invert;
   logic                     pcm_valid;
   logic [NUM_CH*DATA_W-1:0] pcm_data;
   logic                     out_valid;
   logic [NUM_CH*DATA_W-1:0] out_data;

   int errors = 0;
   int checks = 0;

   fe_test_gen #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W), .PER_W(PER_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .mode      (mode),
      .smp_div   (smp_div),
      .tri_inc   (tri_inc),
      .period    (period),
      .ch_enable (ch_enable),
      .ch_invert (ch_invert),
      .pcm_valid (pcm_valid),
      .pcm_data  (pcm_data),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1);
   end

   // Waits (bounded) for the next out_valid; cyc is the number of negedges waited.
   task automatic wait_valid(output logic [47:0] d, output int cyc, output bit ok);
      ok  = 1'b0;
      d   = '0;
      cyc = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            d   = out_data;
            cyc = i;
            ok  = 1'b1;
            return;
         end
      end
   endtask

   task automatic clear_gen();
      run       = 1'b0;
      pcm_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b1; mode = 3'd1; smp_div = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_data !== 48'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", out_data);
      end
      reset = 1'b0; run = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_dc();
      logic [47:0] d; int cyc; bit ok;
      clear_gen();
      mode = 3'd1; smp_div = 12'd3; ch_enable = 2'b11; ch_invert = 2'b00; run = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_valid(d, cyc, ok);
         checks++;
         if (!ok || cyc != ((k == 0) ? 5 : 4) || d !== {MAXP, MAXP}) begin
            errors++;
            $display("FAIL dc_%0d: got ok=%0d gap=%0d data=%h want gap=%0d data=%h",
                     k, ok, cyc, d, (k == 0) ? 5 : 4, {MAXP, MAXP});
         end
      end
   endtask

   task automatic test_triangle();
      logic [47:0] d; int cyc; bit ok;
      logic [23:0] exp_tri [14];
      exp_tri = '{24'h000000, 24'h200000, 24'h400000, 24'h600000, 24'h7FFFFF,
                  24'h5FFFFF, 24'h3FFFFF, 24'h1FFFFF, 24'hFFFFFF, 24'hDFFFFF,
                  24'hBFFFFF, 24'h9FFFFF, 24'h800001, 24'hA00001};
      clear_gen();
      mode = 3'd3; tri_inc = 24'h200000; smp_div = '0; run = 1'b1;
      for (int k = 0; k < 14; k++) begin
         wait_valid(d, cyc, ok);
         checks++;
         if (!ok || d !== {exp_tri[k], exp_tri[k]}) begin
            errors++;
            $display("FAIL tri_%0d: got ok=%0d data=%h want %h", k, ok, d, {exp_tri[k], exp_tri[k]});
         end
      end
   endtask

   task automatic test_impulse();
      logic [47:0] d; int cyc; bit ok;
      logic [23:0] exp_imp [12];
      exp_imp = '{MAXP, 24'h0, 24'h0, 24'h0, 24'h0, MAXP, 24'h0, 24'h0,
                  24'h0, MAXP, 24'h0, MAXP};
      clear_gen();
      mode = 3'd4; period = 10'd4; smp_div = 12'd3; run = 1'b1;
      for (int k = 0; k < 12; k++) begin
         wait_valid(d, cyc, ok);
         checks++;
         if (!ok || d !== {exp_imp[k], exp_imp[k]}) begin
            errors++;
            $display("FAIL impulse_%0d: got ok=%0d data=%h want %h", k, ok, d, {exp_imp[k], exp_imp[k]});
         end
         // After the eighth sample the period counter sits at 3; shorten the period there.
         if (k == 7) period = 10'd1;
      end
   endtask

   task automatic test_bypass();
      clear_gen();
      mode = 3'd0; smp_div = '0; ch_enable = 2'b11; ch_invert = 2'b01; run = 1'b1;
      pcm_data = {24'h123456, 24'h800000};
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bypass_idle: got valid=%b want 0", out_valid);
      end
      pcm_valid = 1'b1;
      @(negedge clk);
      pcm_valid = 1'b0;
      pcm_data  = {24'h0000AA, 24'h0000BB};
      checks++;
      if (out_valid !== 1'b1 || out_data !== {24'h123456, 24'h7FFFFF}) begin
         errors++;
         $display("FAIL bypass_pulse: got valid=%b data=%h want 1 %h", out_valid, out_data, {24'h123456, 24'h7FFFFF});
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== {24'h123456, 24'h7FFFFF}) begin
         errors++;
         $display("FAIL bypass_hold: got valid=%b data=%h want 0 %h", out_valid, out_data, {24'h123456, 24'h7FFFFF});
      end
      ch_invert = 2'b11;
      pcm_data  = {24'h000001, 24'h7FFFFF};
      pcm_valid = 1'b1;
      @(negedge clk);
      pcm_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== {24'hFFFFFF, 24'h800001}) begin
         errors++;
         $display("FAIL bypass_invert: got valid=%b data=%h want 1 %h", out_valid, out_data, {24'hFFFFFF, 24'h800001});
      end
      ch_invert = 2'b00;
   endtask

   task automatic test_square();
      logic [47:0] d; int cyc; bit ok;
      logic [23:0] exp_sq [6];
      exp_sq = '{MINN, MINN, MAXP, MAXP, MINN, MINN};
      clear_gen();
      mode = 3'd5; period = 10'd1; smp_div = 12'd1; ch_enable = 2'b10; ch_invert = 2'b00; run = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_valid(d, cyc, ok);
         checks++;
         if (!ok || d !== {exp_sq[k], 24'h0}) begin
            errors++;
            $display("FAIL square_%0d: got ok=%0d data=%h want %h", k, ok, d, {exp_sq[k], 24'h0});
         end
      end
      ch_enable = 2'b11;
   endtask

   task automatic test_reset_mid();
      logic [47:0] d; int cyc; bit ok;
      logic [23:0] exp_rs [3];
      exp_rs = '{24'h000000, 24'h200000, 24'h400000};
      clear_gen();
      mode = 3'd3; tri_inc = 24'h200000; smp_div = '0; run = 1'b1;
      for (int k = 0; k < 3; k++) wait_valid(d, cyc, ok);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 48'h0) begin
         errors++;
         $display("FAIL reset_mid: got valid=%b data=%h want 0 0", out_valid, out_data);
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_valid(d, cyc, ok);
         checks++;
         if (!ok || d !== {exp_rs[k], exp_rs[k]}) begin
            errors++;
            $display("FAIL restart_%0d: got ok=%0d data=%h want %h", k, ok, d, {exp_rs[k], exp_rs[k]});
         end
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; mode = '0; smp_div = '0; tri_inc = '0; period = '0;
      ch_enable = 2'b11; ch_invert = 2'b00; pcm_valid = 1'b0; pcm_data = '0;
      @(negedge clk);
      test_reset();
      test_dc();
      test_triangle();
      test_impulse();
      test_bypass();
      test_square();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
